// File: rtl/srl16_pkg.sv
// Shared constants for the portable SRL16 / SRL16_1 replacement.
package srl16_pkg;

  localparam int SRL_DEPTH  = 16;
  localparam int SRL_ADDR_W = 4;

  // Power-up / reset contents used when an instance does not override INIT.
  localparam logic [SRL_DEPTH-1:0] SRL_INIT_DEFAULT = 16'h0000;

endpackage

// File: rtl/srl16_lane.sv
// One bit-lane of the shift-register LUT: 16-deep serial shifter with a
// combinational tap mux. The shifting edge is chosen at elaboration time by
// INVERT so the clock net itself is never passed through logic.
module srl16_lane
  import srl16_pkg::*;
#(
  parameter logic [SRL_DEPTH-1:0] INIT   = SRL_INIT_DEFAULT,
  parameter logic                 INVERT = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  D,
  input  logic [SRL_ADDR_W-1:0] A,
  output logic                  Q,
  output logic                  Q15
);

  // data[0] is the newest bit, data[SRL_DEPTH-1] the oldest.
  logic [SRL_DEPTH-1:0] data;

  if (INVERT) begin : g_fall
    // Falling-edge shifter (SRL16_1 behaviour); reset loads INIT immediately.
    always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
        data <= INIT;
      end else if (CE) begin
        data <= {data[SRL_DEPTH-2:0], D};
      end
    end
  end else begin : g_rise
    // Rising-edge shifter (SRL16 behaviour); reset loads INIT immediately.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        data <= INIT;
      end else if (CE) begin
        data <= {data[SRL_DEPTH-2:0], D};
      end
    end
  end

  // Tap read. The uniform-contents shortcuts keep Q known in simulation when
  // A is X/Z; in hardware all three branches reduce to data[A].
  always_comb begin
    Q = data[A];
    if (data == '0) begin
      Q = 1'b0;
    end else if (&data) begin
      Q = 1'b1;
    end
  end

  assign Q15 = data[SRL_DEPTH-1];

endmodule

// File: rtl/srl16_shift_lut.sv
// Vendor-independent SRL16 / SRL16_1 replacement: WIDTH parallel 16-deep
// delay lanes sharing clock, reset, enable and tap address.
module srl16_shift_lut
  import srl16_pkg::*;
#(
  parameter logic [SRL_DEPTH-1:0] INIT   = SRL_INIT_DEFAULT,
  parameter logic                 INVERT = 1'b0,
  parameter int                   WIDTH  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic [WIDTH-1:0]      D,
  input  logic [SRL_ADDR_W-1:0] A,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      Q15
);

  // Edge polarity is resolved per lane through INVERT, selecting a
  // posedge or negedge register process at elaboration.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    srl16_lane #(
      .INIT   (INIT),
      .INVERT (INVERT)
    ) u_lane (
      .CLK (CLK),
      .RST (RST),
      .CE  (CE),
      .D   (D[i]),
      .A   (A),
      .Q   (Q[i]),
      .Q15 (Q15[i])
    );
  end

endmodule

// File: tb/tb_srl16_shift_lut.sv
// Scoreboard bench for srl16_shift_lut: a rising-edge 4-lane instance and a
// falling-edge 1-lane instance, each tracked by a queue-based delay model.
module tb_srl16_shift_lut;

  localparam logic [15:0] INIT0 = 16'hA5C3;
  localparam logic [15:0] INIT1 = 16'h0000;

  logic       clk = 1'b0;
  logic       rst0, ce0;
  logic [3:0] d0, a0, q0, q15_0;
  logic       rst1, ce1;
  logic [0:0] d1, q1, q15_1;
  logic [3:0] a1;

  always #5 clk = ~clk;

  srl16_shift_lut #(.INIT(INIT0), .INVERT(1'b0), .WIDTH(4)) dut0 (
    .CLK(clk), .RST(rst0), .CE(ce0), .D(d0), .A(a0), .Q(q0), .Q15(q15_0)
  );

  srl16_shift_lut #(.INIT(INIT1), .INVERT(1'b1), .WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst1), .CE(ce1), .D(d1), .A(a1), .Q(q1), .Q15(q15_1)
  );

  typedef struct {
    int    dut;
    int    lane;
    bit    is15;
    logic  exp;
    string name;
  } exp_t;

  exp_t        sb[$];
  event        chk_ev;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference: each lane is a list of the last 16 bits, index k = k shifts ago.
  bit          m0[4][$];
  bit          m1[$];
  logic [15:0] init0_v = INIT0;
  logic [15:0] init1_v = INIT1;

  function automatic void reset_m0();
    for (int l = 0; l < 4; l++) begin
      m0[l].delete();
      for (int k = 0; k < 16; k++) m0[l].push_back(init0_v[k]);
    end
  endfunction

  function automatic void shift_m0(logic [3:0] d);
    for (int l = 0; l < 4; l++) begin
      m0[l].push_front(d[l]);
      void'(m0[l].pop_back());
    end
  endfunction

  function automatic void reset_m1();
    m1.delete();
    for (int k = 0; k < 16; k++) m1.push_back(init1_v[k]);
  endfunction

  function automatic void shift_m1(logic d);
    m1.push_front(d);
    void'(m1.pop_back());
  endfunction

  task automatic expect_bit(int dut, int lane, bit is15, logic exp, string name);
    exp_t e;
    e.dut = dut; e.lane = lane; e.is15 = is15; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic fire();
    -> chk_ev;
    #1;
  endtask

  task automatic check0(string name);
    for (int l = 0; l < 4; l++) begin
      expect_bit(0, l, 1'b0, m0[l][a0], name);
      expect_bit(0, l, 1'b1, m0[l][15], {name, "_q15"});
    end
    fire();
  endtask

  task automatic check1(string name);
    expect_bit(1, 0, 1'b0, m1[a1], name);
    expect_bit(1, 0, 1'b1, m1[15], {name, "_q15"});
    fire();
  endtask

  // Called just after a falling edge; applies inputs across one rising edge.
  task automatic step0(logic [3:0] d, bit ce, logic [3:0] a, string name);
    d0 = d; ce0 = ce; a0 = a;
    @(posedge clk);
    if (ce && !rst0) shift_m0(d);
    #1;
    check0(name);
    @(negedge clk);
    #1;
  endtask

  // Called just after a rising edge; shifts on the falling edge, then checks
  // that the following rising edge leaves everything untouched.
  task automatic step1(logic d, bit ce, logic [3:0] a, string name);
    d1[0] = d; ce1 = ce; a1 = a;
    @(negedge clk);
    if (ce && !rst1) shift_m1(d);
    #1;
    check1(name);
    @(posedge clk);
    #1;
    check1({name, "_rise"});
  endtask

  // Monitor: drains the scoreboard whenever a sample point is announced.
  initial begin
    exp_t e;
    logic act;
    forever begin
      @(chk_ev);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.dut == 0) act = e.is15 ? q15_0[e.lane] : q0[e.lane];
        else            act = e.is15 ? q15_1[0] : q1[0];
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s dut%0d lane%0d %s: got %b expected %b", e.name, e.dut,
                   e.lane, e.is15 ? "Q15" : "Q", act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat;
    rst0 = 1'b1; rst1 = 1'b1; ce0 = 1'b1; ce1 = 1'b1;
    d0 = '0; d1 = '0; a0 = '0; a1 = '0;
    reset_m0();
    reset_m1();
    @(negedge clk); #1;

    // Reset held with CE=1 and toggling D: every tap reads INIT.
    for (int a = 0; a < 16; a++) begin
      d0 = 4'($urandom);
      a0 = 4'(a);
      #1;
      vectors++;
      if (q0 !== {4{init0_v[a]}}) begin
        miscompares++;
        $display("FAIL rst_sweep_direct A=%0d: got %b expected %b", a, q0, {4{init0_v[a]}});
      end
      vectors++;
      if (q15_0 !== 4'hF) begin
        miscompares++;
        $display("FAIL rst_q15_direct: got %b expected 1111", q15_0);
      end
      for (int l = 0; l < 4; l++) begin
        expect_bit(0, l, 1'b0, init0_v[a], "rst_sweep");
        expect_bit(0, l, 1'b1, 1'b1, "rst_q15");
      end
      fire();
    end
    check1("rst1");
    @(negedge clk); #1;
    rst0 = 1'b0;

    // Random traffic.
    for (int i = 0; i < 150; i++)
      step0(4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), "rand0");

    // Single pulse down tap 5 after flushing with zeros.
    for (int i = 0; i < 16; i++) step0(4'h0, 1'b1, 4'd5, "flush");
    step0(4'b0001, 1'b1, 4'd5, "pulse_in");
    for (int i = 1; i <= 8; i++) begin
      step0(4'h0, 1'b1, 4'd5, "delay");
      vectors++;
      if (q0[0] !== (i + 1 == 6)) begin
        miscompares++;
        $display("FAIL delay_tap5_direct edge %0d: got %b", i + 1, q0[0]);
      end
      expect_bit(0, 0, 1'b0, (i + 1 == 6), "delay_tap5");
      fire();
    end

    // Hold with CE=0 while D toggles, then sweep every tap.
    for (int i = 0; i < 16; i++) step0(4'($urandom), 1'b1, 4'($urandom), "fill");
    for (int i = 0; i < 10; i++)
      step0(i[0] ? 4'hF : 4'h0, 1'b0, 4'($urandom), "hold");
    ce0 = 1'b0;
    for (int a = 0; a < 16; a++) begin
      a0 = 4'(a);
      #1;
      check0("hold_tap");
    end
    @(negedge clk); #1;

    // Asynchronous reset between edges after 16 ones.
    for (int i = 0; i < 16; i++) step0(4'hF, 1'b1, 4'($urandom), "ones");
    a0 = 4'd7;
    rst0 = 1'b1;
    #1;
    reset_m0();
    for (int l = 0; l < 4; l++) expect_bit(0, l, 1'b0, init0_v[7], "async_rst");
    fire();
    check0("async_rst_model");
    @(negedge clk); #1;
    rst0 = 1'b0;
    step0(4'hF, 1'b1, 4'd0, "post_rst");
    for (int a = 0; a < 16; a++) step0(4'h0, 1'b0, 4'(a), "post_rst_tap");

    // Unknown address over uniform contents.
    for (int i = 0; i < 16; i++) step0(4'h0, 1'b1, 4'd0, "zeros");
    a0 = 'x;
    #1;
    vectors++;
    if (q0 !== 4'h0) begin
      miscompares++;
      $display("FAIL xaddr_zero_direct: got %b expected 0000", q0);
    end
    for (int l = 0; l < 4; l++) expect_bit(0, l, 1'b0, 1'b0, "xaddr_zero");
    fire();
    @(negedge clk); #1;
    for (int i = 0; i < 16; i++) step0(4'hF, 1'b1, 4'd0, "ones2");
    a0 = 'x;
    #1;
    vectors++;
    if (q0 !== 4'hF) begin
      miscompares++;
      $display("FAIL xaddr_one_direct: got %b expected 1111", q0);
    end
    for (int l = 0; l < 4; l++) expect_bit(0, l, 1'b0, 1'b1, "xaddr_one");
    fire();
    a0 = 4'd0;

    // Falling-edge instance: release reset between edges, shift 1,0,1,1.
    @(posedge clk); #1;
    rst1 = 1'b0;
    step1(1'b1, 1'b1, 4'd0, "fall_p0");
    step1(1'b0, 1'b1, 4'd0, "fall_p1");
    step1(1'b1, 1'b1, 4'd0, "fall_p2");
    step1(1'b1, 1'b1, 4'd0, "fall_p3");
    ce1 = 1'b0;
    pat = 4'b1011;
    for (int a = 0; a < 4; a++) begin
      a1 = 4'(a);
      #1;
      vectors++;
      if (q1[0] !== pat[a]) begin
        miscompares++;
        $display("FAIL fall_tap_direct A=%0d: got %b expected %b", a, q1[0], pat[a]);
      end
      expect_bit(1, 0, 1'b0, pat[a], "fall_tap");
      fire();
    end
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++)
      step1(1'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), "rand1");

    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $display("FAIL: %0d miscompares", miscompares);
    else                  $display("PASS");
    $finish;
  end

endmodule
